// File: rtl/pwm_audio_out.sv
// 8-bit PWM speaker driver fed by a 4-entry sample FIFO.
// Each 256-cycle frame latches its duty from the FIFO head; an empty FIFO repeats the last duty and flags underrun.
module pwm_audio_out (
  input  logic       clk,
  input  logic       nRst,
  input  logic       en,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic       clear_underrun,
  output logic       pwm_out,
  output logic       period_start,
  output logic       underrun,
  output logic [2:0] level
);

  // Push handshake: a sample is taken on any edge where sample_valid && sample_ready;
  // sample_ready depends only on registered occupancy, and a refused sample is dropped.

  logic [7:0] r_cnt;
  logic [7:0] r_duty;
  logic [7:0] r_mem [4];
  logic [1:0] r_rd_ptr;
  logic [1:0] r_wr_ptr;
  logic [2:0] r_level;
  logic       r_pwm;
  logic       r_period_start;
  logic       r_underrun;

  logic       w_empty;
  logic       w_full;
  logic       w_wrap;
  logic       w_push;
  logic       w_pop;
  logic [2:0] w_level_next;

  always_comb begin
    w_empty = (r_level == 3'd0);
    w_full  = (r_level == 3'd4);
    w_wrap  = en && (r_cnt == 8'hFF);
    w_push  = sample_valid && !w_full;
    // No bypass: a frame starting on an empty FIFO keeps its duty even if a push lands on the same edge.
    w_pop   = w_wrap && !w_empty;
  end

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + 3'd1;
      2'b01:   w_level_next = r_level - 3'd1;
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < 4; i++) r_mem[i] <= 8'h00;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_level  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_level <= w_level_next;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_cnt  <= 8'h00;
      r_duty <= 8'h80;
    end else begin
      if (en)    r_cnt  <= r_cnt + 8'd1;
      if (w_pop) r_duty <= r_mem[r_rd_ptr];
    end
  end

  // pwm_out compares the pre-edge count against the pre-edge duty, so a new duty shows one cycle after period_start.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_pwm          <= en && (r_cnt < r_duty);
      r_period_start <= w_wrap;
      if (w_wrap && w_empty)  r_underrun <= 1'b1;
      else if (clear_underrun) r_underrun <= 1'b0;
    end
  end

  assign sample_ready = !w_full;
  assign pwm_out      = r_pwm;
  assign period_start = r_period_start;
  assign underrun     = r_underrun;
  assign level        = r_level;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: sample queue scoreboard plus per-frame high-cycle counting.
module tb_pwm_audio_out;

  logic       clk;
  logic       nRst;
  logic       en;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       clear_underrun;
  logic       pwm_out;
  logic       period_start;
  logic       underrun;
  logic [2:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_cnt;
  logic [7:0] m_duty;
  logic       m_ur;
  logic       m_wrap;
  logic       in_frame;
  logic [7:0] frame_duty;
  int         high_cnt;
  int         rises;
  logic       prev_pwm;
  logic       gap;

  pwm_audio_out dut (
    .clk            (clk),
    .nRst           (nRst),
    .en             (en),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .clear_underrun (clear_underrun),
    .pwm_out        (pwm_out),
    .period_start   (period_start),
    .underrun       (underrun),
    .level          (level)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 6 time units after the rising edge, after the falling-edge monitor has run.
  task automatic step();
    @(posedge clk);
    #6;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input logic [7:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_wrap(input int budget, output int k);
    logic seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < budget) begin
      step();
      k++;
      if (period_start === 1'b1) seen = 1'b1;
    end
    if (!seen) check("wrap_timeout", period_start, 1);
  endtask

  // Scoreboard: the falling edge replays the inputs that were sampled on the preceding rising edge.
  always @(negedge clk) begin
    int pre;
    if (!nRst) begin
      m_cnt    = 8'h00;
      m_duty   = 8'h80;
      m_ur     = 1'b0;
      in_frame = 1'b0;
      exp_q.delete();
    end else begin
      pre    = exp_q.size();
      m_wrap = en && (m_cnt == 8'hFF);
      if (m_wrap && pre != 0) m_duty = exp_q.pop_front();
      if (m_wrap && pre == 0) m_ur = 1'b1;
      else if (clear_underrun) m_ur = 1'b0;
      if (sample_valid && pre < 4) exp_q.push_back(sample_in);
      if (en) m_cnt = m_cnt + 8'd1;

      check("period_start", period_start, m_wrap);
      check("level", level, exp_q.size());
      check("sample_ready", sample_ready, exp_q.size() != 4);
      check("underrun", underrun, m_ur);

      if (m_wrap) begin
        if (in_frame) begin
          check("frame_high_cycles", high_cnt, frame_duty);
          if (!gap) check("frame_contiguous", rises, frame_duty != 8'h00);
        end
        check("pwm_at_period_start", pwm_out, 0);
        in_frame   = 1'b1;
        frame_duty = m_duty;
        high_cnt   = 0;
        rises      = 0;
        prev_pwm   = 1'b0;
        gap        = 1'b0;
      end else if (in_frame) begin
        if (pwm_out) high_cnt++;
        if (pwm_out && !prev_pwm) rises++;
        prev_pwm = pwm_out;
        if (!en) gap = 1'b1;
      end
    end
  end

  initial begin
    int k;
    logic [7:0] vals [5];
    vals[0] = 8'h10; vals[1] = 8'h20; vals[2] = 8'h30; vals[3] = 8'h40; vals[4] = 8'h50;

    nRst           = 1'b0;
    en             = 1'b0;
    sample_in      = 8'h00;
    sample_valid   = 1'b0;
    clear_underrun = 1'b0;
    #1;
    check("rst_pwm", pwm_out, 0);
    check("rst_period_start", period_start, 0);
    check("rst_underrun", underrun, 0);
    check("rst_level", level, 0);
    check("rst_ready", sample_ready, 1);
    steps(3);

    // First wrap lands on edge 256 after release with en high.
    nRst = 1'b1;
    en   = 1'b1;
    wait_wrap(400, k);
    check("first_wrap_edge", k, 256);
    check("first_wrap_underrun", underrun, 1);
    check("first_wrap_level", level, 0);

    push(8'h40);
    check("push_level", level, 1);
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    check("clear_underrun", underrun, 0);
    wait_wrap(400, k);
    check("pop_level", level, 0);
    check("pop_no_underrun", underrun, 0);
    wait_wrap(400, k);
    check("empty_wrap_underrun", underrun, 1);

    // Fill past capacity: the fifth sample is refused.
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        check("full_ready", sample_ready, 0);
        check("full_level", level, 4);
      end
      sample_in    = vals[i];
      sample_valid = 1'b1;
      step();
    end
    sample_valid = 1'b0;
    check("after_fill_level", level, 4);
    clear_underrun = 1'b1;
    step();
    clear_underrun = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_wrap(400, k);
      check("drain_level", level, 3 - i);
      check("drain_underrun", underrun, 0);
    end
    wait_wrap(400, k);
    check("drain_empty_underrun", underrun, 1);
    wait_wrap(400, k);

    // Duty extremes.
    push(8'h00);
    push(8'hFF);
    check("extreme_level", level, 2);
    wait_wrap(400, k);
    wait_wrap(400, k);
    wait_wrap(400, k);

    // Enable gap mid-frame while the output is high.
    push(8'hC8);
    wait_wrap(400, k);
    steps(150);
    check("pre_gap_pwm", pwm_out, 1);
    en = 1'b0;
    step();
    check("gap_pwm_low", pwm_out, 0);
    steps(9);
    push(8'h22);
    check("gap_push_level", level, 1);
    steps(89);
    check("gap_no_wrap", period_start, 0);
    en = 1'b1;
    wait_wrap(400, k);
    check("gap_resume_edges", k, 106);
    check("gap_pop_level", level, 0);

    // Set beats clear on the same edge.
    clear_underrun = 1'b1;
    wait_wrap(400, k);
    check("set_wins_underrun", underrun, 1);
    step();
    check("clear_after_set", underrun, 0);
    clear_underrun = 1'b0;

    // Reset mid-frame with three samples queued.
    push(8'h11);
    push(8'h12);
    push(8'h13);
    check("pre_reset_level", level, 3);
    steps(20);
    check("pre_reset_pwm", pwm_out, 1);
    nRst = 1'b0;
    #1;
    check("mid_rst_level", level, 0);
    check("mid_rst_ready", sample_ready, 1);
    check("mid_rst_pwm", pwm_out, 0);
    check("mid_rst_period_start", period_start, 0);
    check("mid_rst_underrun", underrun, 0);
    steps(3);
    nRst = 1'b1;
    wait_wrap(400, k);
    check("post_rst_wrap_edge", k, 256);
    check("post_rst_underrun", underrun, 1);
    wait_wrap(400, k);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Audio output stage that consumes the 8-bit mixed samples produced by the note mixer and drives the speaker pin as an 8-bit PWM waveform. A 4-entry sample FIFO decouples the mixer's divider latency from the fixed 256-cycle PWM frame. Each frame's duty is taken from the FIFO head at the frame boundary. Underruns repeat the last duty and are flagged.

## Interface
- No parameters. FIFO depth is fixed at 4 and PWM resolution at 8 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- nRst  in  1  asynchronous, active-low reset.
- en  in  1  run enable for the PWM counter and FIFO pops.
- sample_in  in  8  unsigned sample from the mixer (0 = silent low, 255 = max).
- sample_valid  in  1  sample_in is valid this cycle.
- sample_ready  out  1  the FIFO can accept a sample this cycle.
- clear_underrun  in  1  clears the sticky underrun flag.
- pwm_out  out  1  registered PWM output to the pad.
- period_start  out  1  one-cycle strobe marking the first cycle of a PWM frame.
- underrun  out  1  sticky flag: a frame started with the FIFO empty.
- level  out  3  FIFO occupancy, 0..4.

## Operation
- Reset values (asynchronous, all outputs and state):
  - cnt = 0, duty = 8'h80, FIFO empty.
  - level = 0, sample_ready = 1.
  - pwm_out = 0, period_start = 0, underrun = 0.
- Push:
  - sample_ready = (level != 4), combinational from registered state.
  - A push occurs when sample_valid && sample_ready; sample_in is written at the tail.
  - sample_valid while not ready: the sample is dropped; nothing changes.
- PWM counter:
  - 8-bit cnt increments by 1 on each edge while en = 1 and wraps 255 -> 0.
  - While en = 0, cnt holds its value.
- Frame boundary (wrap edge): the edge where en = 1 and cnt = 255.
  - FIFO non-empty: duty <= FIFO head, pop one entry.
  - FIFO empty: duty holds, no pop, underrun <= 1.
- Output:
  - pwm_out <= en && (cnt < duty), using the pre-edge cnt and duty.
  - duty = 0 gives pwm_out constantly 0; duty = 255 gives 255 high cycles per 256.
- period_start <= (wrap edge occurring). It is high for exactly one cycle, the cycle in which cnt = 0.
- Simultaneous push and pop (1 <= level <= 3): both occur and level is unchanged. FIFO order is preserved.
- Simultaneous push and pop attempt at level 0: the pop fails (underrun set, duty held) and the pushed sample is stored. There is no bypass path; level becomes 1.
- Push at level 4 during a pop: the push is rejected because sample_ready was 0. level becomes 3.
- underrun:
  - Set by an empty-FIFO wrap edge.
  - Cleared by clear_underrun.
  - If set and clear happen on the same edge, set wins.
- en = 0:
  - pwm_out goes 0 at the next edge.
  - No wraps occur, so there are no pops and no underruns.
  - Pushes are still accepted.
  - When en returns to 1, cnt resumes from its held value.
- Reset asserted mid-frame: all state returns immediately to the reset values. The FIFO contents are discarded.

## Timing
- The frame is 256 enabled cycles.
- pwm_out is high for exactly `duty` consecutive cycles, starting the cycle after period_start.
- Push-to-ready latency: the level update is visible one cycle after the push edge.
- Sample latency: a sample pushed into an empty FIFO affects pwm_out starting one cycle after the next period_start.
- First wrap after reset with en held at 1: the wrap edge is edge 256.
  - cnt reaches 255 after edge 255.
  - period_start is high after edge 256.

## Test plan
- Reset with en = 1 and no samples:
  - pwm_out is high 128 cycles per frame.
  - period_start pulses every 256 cycles.
  - underrun = 1 after the first wrap.
  - level stays 0.
- Push 8'h40 before the first wrap:
  - The next frame has exactly 64 high cycles, beginning 1 cycle after period_start.
  - level goes 1 -> 0 at the wrap.
- Push 0x10, 0x20, 0x30, 0x40, 0x50 back-to-back:
  - The first four are accepted and level = 4.
  - sample_ready = 0 during the 5th; 0x50 is dropped.
  - The following frames show 16, 32, 48, 64 high cycles.
  - After that, 64 repeats and underrun is set.
- Duty extremes: push 0x00 then 0xFF -> one frame with 0 high cycles, then one with 255 high cycles.
- en = 0 for 100 cycles mid-frame:
  - pwm_out is 0 and cnt holds.
  - A push still raises level.
  - After en returns to 1, the frame completes with the remaining count; total enabled cycles are still 256.
- Set and clear on the same edge: clear_underrun held high across an empty wrap -> underrun = 1; it clears on the next edge.
- Reset mid-frame: drop nRst with level = 3 -> all outputs take their reset values immediately and level = 0.
